// File: rtl/ac_unit_p.sv
// Accumulator unit: AC register, E link flip-flop, status flags and an ALU
// for decoded register/memory-reference commands, plus multi-cycle N-bit circulates.
module ac_unit_p #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    input  logic [3:0]         op,
    output logic               op_ready,
    input  logic [WIDTH-1:0]   dr,
    input  logic [7:0]         inpr,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   ac,
    output logic               e,
    output logic               ovf,
    output logic               zero,
    output logic               neg,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_LDA  = 4'd3;
    localparam logic [3:0] OP_CLA  = 4'd4;
    localparam logic [3:0] OP_CLE  = 4'd5;
    localparam logic [3:0] OP_CMA  = 4'd6;
    localparam logic [3:0] OP_CME  = 4'd7;
    localparam logic [3:0] OP_CIR  = 4'd8;
    localparam logic [3:0] OP_CIL  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd10;
    localparam logic [3:0] OP_INP  = 4'd11;
    localparam logic [3:0] OP_RORN = 4'd12;
    localparam logic [3:0] OP_ROLN = 4'd13;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [WIDTH-1:0]   ac_q, ac_d;
    logic               e_q, e_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;

    logic               accept;
    logic [WIDTH:0]     sum;

    // One step of the WIDTH+1-bit ring {e, ac}; returns {new_ac, new_e}.
    function automatic logic [WIDTH:0] ring_step(input logic [WIDTH-1:0] a,
                                                 input logic le,
                                                 input logic to_left);
        if (to_left)
            ring_step = {a[WIDTH-2:0], le, a[WIDTH-1]};
        else
            ring_step = {le, a[WIDTH-1:1], a[0]};
    endfunction

    assign accept = op_valid && !busy_q;
    assign sum    = {1'b0, ac_q} + {1'b0, dr};

    always_comb begin
        ac_d   = ac_q;
        e_d    = e_q;
        ovf_d  = ovf_q;
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        left_d = left_q;

        if (busy_q) begin
            {ac_d, e_d} = ring_step(ac_q, e_q, left_q);
            cnt_d       = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (accept) begin
            done_d = 1'b1;
            case (op)
                OP_AND: ac_d = ac_q & dr;
                OP_ADD: begin
                    {e_d, ac_d} = sum;
                    ovf_d = (ac_q[WIDTH-1] == dr[WIDTH-1]) &&
                            (sum[WIDTH-1] != ac_q[WIDTH-1]);
                end
                OP_LDA: ac_d = dr;
                OP_CLA: begin
                    ac_d  = '0;
                    ovf_d = 1'b0;
                end
                OP_CLE: e_d = 1'b0;
                OP_CMA: ac_d = ~ac_q;
                OP_CME: e_d = ~e_q;
                OP_CIR: {ac_d, e_d} = ring_step(ac_q, e_q, 1'b0);
                OP_CIL: {ac_d, e_d} = ring_step(ac_q, e_q, 1'b1);
                OP_INC: ac_d = ac_q + WIDTH'(1);
                OP_INP: ac_d[7:0] = inpr;
                OP_RORN, OP_ROLN: begin
                    // The accept edge performs the first step; the rest run while busy.
                    if (shamt != '0) begin
                        left_d      = (op == OP_ROLN);
                        {ac_d, e_d} = ring_step(ac_q, e_q, op == OP_ROLN);
                        cnt_d       = shamt - CNT_ONE;
                        if (shamt != CNT_ONE) begin
                            busy_d = 1'b1;
                            done_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q   <= '0;
            e_q    <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else begin
            ac_q   <= ac_d;
            e_q    <= e_d;
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            left_q <= left_d;
        end
    end

    assign ac       = ac_q;
    assign e        = e_q;
    assign ovf      = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign op_ready = ~busy_q;
    assign zero     = (ac_q == '0);
    assign neg      = ac_q[WIDTH-1];

endmodule

// File: tb/tb_ac_unit_p.sv
// Directed bench for ac_unit_p (WIDTH=16): hand-computed vectors for each
// command, flag rules, multi-cycle circulates and mid-circulate reset.
module tb_ac_unit_p;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  logic               clk;
  logic               rst_n;
  logic               op_valid;
  logic [3:0]         op;
  logic               op_ready;
  logic [WIDTH-1:0]   dr;
  logic [7:0]         inpr;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   ac;
  logic               e;
  logic               ovf;
  logic               zero;
  logic               neg;
  logic               busy;
  logic               done;

  int n_cmp;
  int n_err;

  ac_unit_p #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .op_ready (op_ready),
    .dr       (dr),
    .inpr     (inpr),
    .shamt    (shamt),
    .ac       (ac),
    .e        (e),
    .ovf      (ovf),
    .zero     (zero),
    .neg      (neg),
    .busy     (busy),
    .done     (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one command for a single accept edge; returns at the following
  // falling edge, where done and the new ac/e are visible.
  task automatic issue(input logic [3:0] o, input logic [WIDTH-1:0] d,
                       input logic [7:0] ip, input logic [SHAMT_W-1:0] sh);
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    dr       = d;
    inpr     = ip;
    shamt    = sh;
    @(negedge clk);
    op_valid = 1'b0;
    dr       = '0;
    inpr     = '0;
    shamt    = '0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op       = '0;
    dr       = '0;
    inpr     = '0;
    shamt    = '0;

    repeat (2) @(negedge clk);
    check("rst_ac", ac, 0);
    check("rst_e", e, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 1);
    check("rst_neg", neg, 0);
    check("rst_ready", op_ready, 1);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_done", done, 0);

    // ADD carry out and signed overflow
    issue(4'd3, 16'hFFFF, 8'h00, 0);
    check("lda_ac", ac, 16'hFFFF);
    check("lda_done", done, 1);
    issue(4'd2, 16'h0001, 8'h00, 0);
    check("add1_ac", ac, 16'h0000);
    check("add1_e", e, 1);
    check("add1_zero", zero, 1);
    check("add1_ovf", ovf, 0);
    check("add1_done", done, 1);
    issue(4'd3, 16'h7FFF, 8'h00, 0);
    check("lda2_e_kept", e, 1);
    issue(4'd2, 16'h0001, 8'h00, 0);
    check("add2_ac", ac, 16'h8000);
    check("add2_ovf", ovf, 1);
    check("add2_neg", neg, 1);
    check("add2_e", e, 0);
    issue(4'd1, 16'hF0F0, 8'h00, 0);
    check("and_ac", ac, 16'h8000);
    check("and_ovf_kept", ovf, 1);

    // single-bit circulates and INC
    issue(4'd3, 16'h8001, 8'h00, 0);
    issue(4'd9, 16'h0000, 8'h00, 0);
    check("cil_ac", ac, 16'h0002);
    check("cil_e", e, 1);
    issue(4'd8, 16'h0000, 8'h00, 0);
    check("cir_ac", ac, 16'h8001);
    check("cir_e", e, 0);
    issue(4'd7, 16'h0000, 8'h00, 0);
    check("cme_e", e, 1);
    issue(4'd3, 16'hFFFF, 8'h00, 0);
    issue(4'd10, 16'h0000, 8'h00, 0);
    check("inc_ac", ac, 16'h0000);
    check("inc_e_kept", e, 1);
    check("inc_ovf_kept", ovf, 1);

    // INP, CMA, CLA, CLE, NOP, reserved
    issue(4'd3, 16'h1234, 8'h00, 0);
    issue(4'd11, 16'h0000, 8'hA5, 0);
    check("inp_ac", ac, 16'h12A5);
    issue(4'd6, 16'h0000, 8'h00, 0);
    check("cma_ac", ac, 16'hED5A);
    issue(4'd4, 16'h0000, 8'h00, 0);
    check("cla_ac", ac, 16'h0000);
    check("cla_ovf", ovf, 0);
    check("cla_e_kept", e, 1);
    issue(4'd5, 16'h0000, 8'h00, 0);
    check("cle_e", e, 0);
    issue(4'd3, 16'h00C3, 8'h00, 0);
    issue(4'd0, 16'hFFFF, 8'hFF, 0);
    check("nop_ac", ac, 16'h00C3);
    check("nop_done", done, 1);
    issue(4'd15, 16'hFFFF, 8'hFF, 0);
    check("rsv_ac", ac, 16'h00C3);
    check("rsv_done", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // ROLN 3 from ac=0x8000, e=0, with a CLA offered while busy
    issue(4'd3, 16'h8000, 8'h00, 0);
    @(negedge clk);
    op_valid = 1'b1;
    op       = 4'd13;
    shamt    = 3;
    @(negedge clk);
    op       = 4'd4;
    shamt    = 7;
    dr       = 16'hFFFF;
    check("roln_s1_busy", busy, 1);
    check("roln_s1_ready", op_ready, 0);
    check("roln_s1_done", done, 0);
    check("roln_s1_ac", ac, 16'h0000);
    check("roln_s1_e", e, 1);
    @(negedge clk);
    check("roln_s2_ready", op_ready, 0);
    check("roln_s2_done", done, 0);
    check("roln_s2_ac", ac, 16'h0001);
    @(negedge clk);
    op_valid = 1'b0;
    check("roln_ac", ac, 16'h0002);
    check("roln_e", e, 0);
    check("roln_done", done, 1);
    check("roln_busy", busy, 0);
    @(negedge clk);
    check("roln_done_once", done, 0);
    check("roln_cla_ignored", ac, 16'h0002);

    issue(4'd13, 16'h0000, 8'h00, 0);
    check("roln0_ac", ac, 16'h0002);
    check("roln0_done", done, 1);
    check("roln0_busy", busy, 0);
    issue(4'd12, 16'h0000, 8'h00, 1);
    check("rorn1_ac", ac, 16'h0001);
    check("rorn1_e", e, 0);
    check("rorn1_done", done, 1);
    check("rorn1_busy", busy, 0);

    // RORN 15 aborted by reset at step 5
    issue(4'd3, 16'h00FF, 8'h00, 0);
    @(negedge clk);
    op_valid = 1'b1;
    op       = 4'd12;
    shamt    = 15;
    @(negedge clk);
    op_valid = 1'b0;
    check("rorn15_s1_ac", ac, 16'h007F);
    check("rorn15_s1_e", e, 1);
    repeat (3) @(negedge clk);
    check("rorn15_s4_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ac", ac, 0);
    check("abort_e", e, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready", op_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_done", done, 0);
    check("post_abort_ac", ac, 0);
    issue(4'd3, 16'h00F0, 8'h00, 0);
    check("post_lda_ac", ac, 16'h00F0);
    check("post_lda_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
